// File: rtl/accu_pkg.sv
// Shared constants, helpers and drain FSM encoding for the accumulation
// output buffer datapath.
package accu_pkg;

   localparam int default_nb_pe_row    = 8;
   localparam int default_buffer_width = 16;
   localparam int default_buffer_depth = 8192;
   localparam int default_out_width    = 8;
   localparam int default_fifo_depth   = 4;

   // Ceiling log2; a value of 1 yields 0.
   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         v = v >> 1;
         r++;
      end
      return r;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } drain_state_t;

endpackage

// File: rtl/accu_requant_lane.sv
// One lane of requantisation: optional ReLU, round-half-up arithmetic right
// shift, then saturation to out_width.
module accu_requant_lane
   import accu_pkg::*;
#(
   parameter int buffer_width = default_buffer_width,
   parameter int out_width    = default_out_width
)(
   input  logic signed [buffer_width-1:0] x,
   input  logic        [3:0]              shift,
   input  logic                           relu_en,
   output logic signed [out_width-1:0]    y
);

   localparam int ext_width = buffer_width + 1;

   logic signed [ext_width-1:0] x_ext;
   logic signed [ext_width-1:0] rnd;
   logic signed [ext_width-1:0] t;
   logic signed [ext_width-1:0] q;
   logic signed [ext_width-1:0] sat_max;
   logic signed [ext_width-1:0] sat_min;

   assign sat_max = {{(ext_width-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
   assign sat_min = {{(ext_width-out_width+1){1'b1}}, {(out_width-1){1'b0}}};

   // One guard bit keeps the rounding add from overflowing at full scale.
   always_comb begin
      x_ext = (relu_en && x[buffer_width-1]) ? '0 : {x[buffer_width-1], x};
      rnd   = '0;
      if (shift != 4'd0) begin
         rnd[shift - 4'd1] = 1'b1;
      end
      t = x_ext + rnd;
      q = t >>> shift;
      if (q > sat_max) begin
         y = sat_max[out_width-1:0];
      end else if (q < sat_min) begin
         y = sat_min[out_width-1:0];
      end else begin
         y = q[out_width-1:0];
      end
   end

endmodule

// File: rtl/accu_outbuffer_drain.sv
// Drains a programmed address range of the accumulation buffer, requantises
// each lane and streams rows out through a credit-protected skid FIFO.
module accu_outbuffer_drain
   import accu_pkg::*;
#(
   parameter int nb_pe_row         = default_nb_pe_row,
   parameter int buffer_width      = default_buffer_width,
   parameter int buffer_depth      = default_buffer_depth,
   parameter int buffer_addr_width = clogb2(buffer_depth),
   parameter int out_width         = default_out_width,
   parameter int fifo_depth        = default_fifo_depth
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [buffer_addr_width-1:0]      base_addr,
   input  logic [buffer_addr_width:0]        nb_words,
   input  logic [3:0]                        shift,
   input  logic                              relu_en,
   output logic [buffer_addr_width-1:0]      rAddr,
   output logic                              rEn,
   input  logic [nb_pe_row*buffer_width-1:0] buffer_out_all_rows,
   output logic [nb_pe_row*out_width-1:0]    out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              busy,
   output logic                              done
);

   localparam int row_width = nb_pe_row * out_width;
   localparam int fifo_aw   = clogb2(fifo_depth);
   localparam logic [fifo_aw+1:0] credit_limit = (fifo_aw+2)'(fifo_depth);
   localparam logic [buffer_addr_width-1:0] addr_last = buffer_addr_width'(buffer_depth - 1);

   drain_state_t state, state_nxt;

   logic [buffer_addr_width:0]   issued;
   logic [buffer_addr_width:0]   nb_words_r;
   logic [buffer_addr_width-1:0] addr_r;
   logic [3:0]                   shift_r;
   logic                         relu_r;
   logic                         inflight;

   logic [row_width-1:0] mem [fifo_depth];
   logic [fifo_aw-1:0]   wr_ptr;
   logic [fifo_aw-1:0]   rd_ptr;
   logic [fifo_aw:0]     count;
   logic [fifo_aw:0]     count_nxt;
   logic [fifo_aw+1:0]   credit_used;
   logic [row_width-1:0] row_q;
   logic                 issue;
   logic                 push;
   logic                 pop;

   for (genvar i = 0; i < nb_pe_row; i++) begin : g_lane
      accu_requant_lane #(
         .buffer_width (buffer_width),
         .out_width    (out_width)
      ) u_lane (
         .x       (buffer_out_all_rows[(i+1)*buffer_width-1 -: buffer_width]),
         .shift   (shift_r),
         .relu_en (relu_r),
         .y       (row_q[(i+1)*out_width-1 -: out_width])
      );
   end

   // Words in flight count against FIFO space so a full FIFO is never overrun.
   assign credit_used = (fifo_aw+2)'(count) + (fifo_aw+2)'(inflight);
   assign issue       = (state == RUN) && (issued != nb_words_r) && (credit_used < credit_limit);
   assign push        = inflight;
   assign pop         = out_valid && out_ready;
   assign count_nxt   = count + (fifo_aw+1)'(push) - (fifo_aw+1)'(pop);

   assign rEn       = issue;
   assign rAddr     = addr_r;
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   // FLUSH looks at next-cycle occupancy so done lands right after the last pop.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (nb_words != '0) ? RUN : DONE;
         RUN:     if (issue && (issued + (buffer_addr_width+1)'(1) == nb_words_r)) state_nxt = FLUSH;
         FLUSH:   if (!inflight && (count_nxt == '0)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         issued     <= '0;
         nb_words_r <= '0;
         addr_r     <= '0;
         shift_r    <= '0;
         relu_r     <= 1'b0;
         inflight   <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if ((state == IDLE) && start) begin
            issued     <= '0;
            nb_words_r <= nb_words;
            addr_r     <= base_addr;
            shift_r    <= shift;
            relu_r     <= relu_en;
         end else if (issue) begin
            issued <= issued + (buffer_addr_width+1)'(1);
            addr_r <= (addr_r == addr_last) ? '0 : addr_r + buffer_addr_width'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < fifo_depth; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= row_q;
            wr_ptr      <= wr_ptr + fifo_aw'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + fifo_aw'(1);
         end
         count <= count_nxt;
      end
   end

endmodule
